// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator execution stage.
package calc_pkg;

    // The multiply/divide datapath runs one iteration per operand bit.
    localparam int ITER = 16;

    // Operator codes as delivered by the command decoder.
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4;

    // Operand type codes.
    localparam logic [3:0] DT_UNSIGNED = 4'h0;
    localparam logic [3:0] DT_SIGNED   = 4'h1;

    // Iterative datapath mode select.
    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_OUT
    } state_t;

endpackage

// File: rtl/calc_muldiv.sv
// Iterative unsigned multiplier / restoring divider working on operand
// magnitudes. Loaded by i_start, advanced once per cycle by i_step; the
// caller owns the iteration counter and o_last flags its final value.
module calc_muldiv
    import calc_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic                       i_mode,
    input  logic [WIDTH-1:0]           i_a,
    input  logic [WIDTH-1:0]           i_b,
    input  logic                       i_step,
    input  logic [$clog2(WIDTH)-1:0]   i_cnt,
    output logic                       o_last,
    output logic [2*WIDTH-1:0]         o_prod,
    output logic [WIDTH-1:0]           o_quot,
    output logic [WIDTH-1:0]           o_rem
);

    localparam int CW = $clog2(WIDTH);

    logic                 r_mode;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_prod;   // {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]     r_quot;   // dividend shifts out the top, quotient in the bottom
    logic [WIDTH-1:0]     r_rem;

    logic [WIDTH:0]       w_add;
    logic [2*WIDTH-1:0]   w_prod_next;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH+1:0]     w_diff;
    logic                 w_fits;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quot_next;

    // One shift-add step and one restoring-divide step, both computed every cycle.
    always_comb begin
        w_add       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_b} : '0);
        w_prod_next = {w_add, r_prod[WIDTH-1:1]};
        w_shift     = {r_rem, r_quot[WIDTH-1]};
        w_diff      = {1'b0, w_shift} - {2'b00, r_b};
        w_fits      = ~w_diff[WIDTH+1];
        // Either branch is below the divisor, so it fits in WIDTH bits.
        w_rem_next  = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quot_next = {r_quot[WIDTH-2:0], w_fits};
    end

    // Operand load on start, then one iteration per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MD_MUL;
            r_b    <= '0;
            r_prod <= '0;
            r_quot <= '0;
            r_rem  <= '0;
        end else if (i_start) begin
            r_mode <= i_mode;
            r_b    <= i_b;
            r_prod <= {{WIDTH{1'b0}}, i_a};
            r_quot <= i_a;
            r_rem  <= '0;
        end else if (i_step) begin
            if (r_mode == MD_MUL) begin
                r_prod <= w_prod_next;
            end else begin
                r_quot <= w_quot_next;
                r_rem  <= w_rem_next;
            end
        end
    end

    assign o_last = i_step && (i_cnt == CW'(WIDTH - 1));
    assign o_prod = r_prod;
    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/calc_core.sv
// Calculator execution stage: accepts one decoded command per done strobe,
// computes ADD/SUB directly and MUL/DIV/MOD on magnitudes through the
// iterative datapath, then applies the sign and emits a one-cycle result.
module calc_core
    import calc_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           dtype,
    input  logic [4:0]           op,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 res_valid,
    output logic                 err,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [4:0]           r_op;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_res_valid;
    logic                 r_err;
    logic                 r_busy;

    logic                 w_signed;
    logic                 w_neg1;
    logic                 w_neg2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic [2*WIDTH-1:0]   w_ext1;
    logic [2*WIDTH-1:0]   w_ext2;
    logic                 w_res_neg;
    logic                 w_is_divmod;
    logic                 w_cmd_err;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_step;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [2*WIDTH-1:0]   w_mag_res;

    // Command decode: extension, magnitudes, result sign and error detection.
    always_comb begin
        w_signed    = (dtype == DT_SIGNED);
        w_neg1      = w_signed && src1[WIDTH-1];
        w_neg2      = w_signed && src2[WIDTH-1];
        // Two's complement negation of the most negative value yields its
        // correct unsigned magnitude, so no special case is needed.
        w_mag1      = w_neg1 ? -src1 : src1;
        w_mag2      = w_neg2 ? -src2 : src2;
        w_ext1      = {{WIDTH{w_neg1}}, src1};
        w_ext2      = {{WIDTH{w_neg2}}, src2};
        w_res_neg   = (op == OP_MOD) ? w_neg1 : (w_neg1 ^ w_neg2);
        w_is_divmod = (op == OP_DIV) || (op == OP_MOD);
        w_cmd_err   = ((dtype != DT_UNSIGNED) && (dtype != DT_SIGNED))
                   || (op > OP_MOD)
                   || (w_is_divmod && (src2 == '0));
        w_accept    = (r_state == S_IDLE) && done;
        w_start     = w_accept && !w_cmd_err && ((op == OP_MUL) || w_is_divmod);
        w_step      = (r_state == S_MUL) || (r_state == S_DIV);
    end

    calc_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_mode  ((op == OP_MUL) ? MD_MUL : MD_DIV),
        .i_a     (w_mag1),
        .i_b     (w_mag2),
        .i_step  (w_step),
        .i_cnt   (r_cnt),
        .o_last  (w_last),
        .o_prod  (w_prod),
        .o_quot  (w_quot),
        .o_rem   (w_rem)
    );

    // Unsigned magnitude of the iterative result, selected by captured op.
    always_comb begin
        w_mag_res = w_prod;
        if (r_op == OP_DIV) begin
            w_mag_res = {{WIDTH{1'b0}}, w_quot};
        end else if (r_op == OP_MOD) begin
            w_mag_res = {{WIDTH{1'b0}}, w_rem};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; done outside IDLE is simply ignored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (done) begin
                    if (w_cmd_err || (op == OP_ADD) || (op == OP_SUB)) begin
                        w_state_next = S_OUT;
                    end else if (op == OP_MUL) begin
                        w_state_next = S_MUL;
                    end else begin
                        w_state_next = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_OUT;
            S_OUT:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Capture, iteration counting, sign fix-up and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_op        <= OP_ADD;
            r_neg       <= 1'b0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_res_valid <= (w_state_next == S_OUT);
            r_busy      <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_neg <= w_res_neg;
                        r_err <= w_cmd_err;
                        r_cnt <= '0;
                        if (w_cmd_err) begin
                            r_result <= '0;
                        end else if (op == OP_ADD) begin
                            r_result <= w_ext1 + w_ext2;
                        end else if (op == OP_SUB) begin
                            r_result <= w_ext1 - w_ext2;
                        end
                    end
                end
                S_MUL, S_DIV: r_cnt <= r_cnt + 1'b1;
                S_FIX:        r_result <= r_neg ? -w_mag_res : w_mag_res;
                default:      ;
            endcase
        end
    end

    assign result    = r_result;
    assign res_valid = r_res_valid;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule
